// File: rtl/i2c_cam_cfg_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_cam_cfg_seq_if
// Brief    : Control/status and table-lookup bundle of the camera config sequencer.
// Revision : 1.0
// ============================================================================
interface i2c_cam_cfg_seq_if #(
  parameter int IDX_W = 4,
  parameter int BYTES = 3
);
  logic                 iStart;
  logic                 iUpdate;
  logic [IDX_W-1:0]     oLUT_INDEX;
  logic [8*BYTES-1:0]   iLUT_DATA;
  logic                 oBusy;
  logic                 oDone;
  logic                 oError;

  modport slave  (input  iStart, iUpdate, iLUT_DATA,
                  output oLUT_INDEX, oBusy, oDone, oError);
  modport master (output iStart, iUpdate, iLUT_DATA,
                  input  oLUT_INDEX, oBusy, oDone, oError);
endinterface
`default_nettype wire

// File: rtl/i2c_cam_cfg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_cam_cfg_seq
// Brief    : Camera-sensor I2C register-write sequencer with NACK retry,
//            partial range re-write and an open-drain bit-level master.
// Revision : 1.0
// ============================================================================
module i2c_cam_cfg_seq #(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          I2C_FREQ   = 100000,
  parameter logic [7:0]  SLAVE_ADDR = 8'hBA,
  parameter int          BYTES      = 3,
  parameter int          LUT_SIZE   = 8,
  parameter int          IDX_W      = 4,
  parameter int          UPD_FIRST  = 1,
  parameter int          UPD_LAST   = 1,
  parameter int          MAX_RETRY  = 3,
  parameter int          AUTO_START = 1
) (
  input  wire logic           iCLK,
  input  wire logic           iRST,
  i2c_cam_cfg_seq_if.slave    cfgBus,
  output logic                I2C_SCLK,
  inout  wire                 I2C_SDAT
);

  localparam int c_DIV   = CLK_FREQ / (4 * I2C_FREQ);
  localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_BC_W  = $clog2(BYTES + 1);
  localparam int c_RT_W  = $clog2(MAX_RETRY + 2);
  localparam logic [IDX_W-1:0] c_IDX_MAX = IDX_W'(LUT_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_BYTE, S_ACK, S_STOP, S_GAP
  } state_t;

  state_t                r_state, w_stateNext;
  logic [c_DIV_W-1:0]    r_divCnt;
  logic                  w_tick;
  logic [1:0]            r_phase, w_phaseNext;
  logic [2:0]            r_bitCnt, w_bitNext;
  logic [c_BC_W-1:0]     r_byteCnt, w_byteNext;
  logic [7:0]            r_shift, w_shiftNext;
  logic [8*BYTES-1:0]    r_data, w_dataNext;
  logic [IDX_W-1:0]      r_idx, w_idxNext;
  logic [IDX_W-1:0]      r_last, w_lastNext;
  logic [c_RT_W-1:0]     r_retry, w_retryNext;
  logic                  r_nack, w_nackNext;
  logic                  r_scl, w_sclNext;
  logic                  r_sdaLow, w_sdaLowNext;
  logic                  r_busy, w_busyNext;
  logic                  r_done, w_doneNext;
  logic                  r_error, w_errorNext;
  logic                  r_pend, w_pendNext;
  logic                  r_autoGo, w_autoNext;
  logic                  w_sdaIn;

  assign w_sdaIn           = I2C_SDAT;
  assign I2C_SDAT          = r_sdaLow ? 1'b0 : 1'bz;
  assign I2C_SCLK          = r_scl;
  assign cfgBus.oLUT_INDEX = r_idx;
  assign cfgBus.oBusy      = r_busy;
  assign cfgBus.oDone      = r_done;
  assign cfgBus.oError     = r_error;

  // Free-running quarter-bit strobe
  assign w_tick = (r_divCnt == c_DIV_W'(c_DIV - 1));

  always_ff @(posedge iCLK) begin
    if (iRST || w_tick) r_divCnt <= '0;
    else                r_divCnt <= r_divCnt + 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_bitCnt  <= '0;
      r_byteCnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_retry   <= '0;
      r_nack    <= 1'b0;
      r_scl     <= 1'b1;
      r_sdaLow  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_pend    <= 1'b0;
      r_autoGo  <= (AUTO_START != 0);
    end else begin
      r_state   <= w_stateNext;
      r_phase   <= w_phaseNext;
      r_bitCnt  <= w_bitNext;
      r_byteCnt <= w_byteNext;
      r_shift   <= w_shiftNext;
      r_data    <= w_dataNext;
      r_idx     <= w_idxNext;
      r_last    <= w_lastNext;
      r_retry   <= w_retryNext;
      r_nack    <= w_nackNext;
      r_scl     <= w_sclNext;
      r_sdaLow  <= w_sdaLowNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_error   <= w_errorNext;
      r_pend    <= w_pendNext;
      r_autoGo  <= w_autoNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_phaseNext  = r_phase;
    w_bitNext    = r_bitCnt;
    w_byteNext   = r_byteCnt;
    w_shiftNext  = r_shift;
    w_dataNext   = r_data;
    w_idxNext    = r_idx;
    w_lastNext   = r_last;
    w_retryNext  = r_retry;
    w_nackNext   = r_nack;
    w_sclNext    = r_scl;
    w_sdaLowNext = r_sdaLow;
    w_busyNext   = r_busy;
    w_doneNext   = r_done;
    w_errorNext  = r_error;
    w_pendNext   = r_pend;
    w_autoNext   = r_autoGo;

    if (r_state != S_IDLE && cfgBus.iUpdate) w_pendNext = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (r_autoGo || cfgBus.iStart || r_pend || cfgBus.iUpdate) begin
          // A full-run request outranks and swallows any update request
          if (r_autoGo || cfgBus.iStart) begin
            w_idxNext  = '0;
            w_lastNext = c_IDX_MAX;
          end else begin
            w_idxNext  = IDX_W'(UPD_FIRST);
            w_lastNext = IDX_W'(UPD_LAST);
          end
          w_pendNext  = 1'b0;
          w_autoNext  = 1'b0;
          w_retryNext = '0;
          w_busyNext  = 1'b1;
          w_doneNext  = 1'b0;
          w_errorNext = 1'b0;
          w_phaseNext = '0;
          w_stateNext = S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_phase == 2'd0) begin
          w_phaseNext = 2'd1;
        end else begin
          w_dataNext  = cfgBus.iLUT_DATA;
          w_shiftNext = SLAVE_ADDR;
          w_byteNext  = '0;
          w_bitNext   = '0;
          w_nackNext  = 1'b0;
          w_phaseNext = '0;
          w_stateNext = S_START;
        end
      end
      S_START: if (w_tick) begin
        w_phaseNext = r_phase + 2'd1;
        case (r_phase)
          2'd0:    w_sdaLowNext = 1'b1;
          2'd2:    w_sclNext    = 1'b0;
          2'd3:    w_stateNext  = S_BYTE;
          default: ;
        endcase
      end
      S_BYTE: if (w_tick) begin
        w_phaseNext = r_phase + 2'd1;
        case (r_phase)
          2'd0:    w_sdaLowNext = ~r_shift[7];
          2'd1:    w_sclNext    = 1'b1;
          2'd3: begin
            w_sclNext   = 1'b0;
            w_shiftNext = {r_shift[6:0], 1'b0};
            if (r_bitCnt == 3'd7) begin
              w_bitNext   = '0;
              w_stateNext = S_ACK;
            end else begin
              w_bitNext   = r_bitCnt + 3'd1;
            end
          end
          default: ;
        endcase
      end
      S_ACK: if (w_tick) begin
        w_phaseNext = r_phase + 2'd1;
        case (r_phase)
          2'd0:    w_sdaLowNext = 1'b0;
          2'd1:    w_sclNext    = 1'b1;
          2'd2:    if (w_sdaIn) w_nackNext = 1'b1;
          2'd3: begin
            w_sclNext = 1'b0;
            if (r_nack || r_byteCnt == c_BC_W'(BYTES)) begin
              w_stateNext = S_STOP;
            end else begin
              w_shiftNext = r_data[8*BYTES-1 -: 8];
              w_dataNext  = r_data << 8;
              w_byteNext  = r_byteCnt + 1'b1;
              w_stateNext = S_BYTE;
            end
          end
          default: ;
        endcase
      end
      S_STOP: if (w_tick) begin
        w_phaseNext = r_phase + 2'd1;
        case (r_phase)
          2'd0:    w_sdaLowNext = 1'b1;
          2'd1:    w_sclNext    = 1'b1;
          2'd2:    w_sdaLowNext = 1'b0;
          2'd3:    w_stateNext  = S_GAP;
          default: ;
        endcase
      end
      S_GAP: if (w_tick) begin
        w_phaseNext = r_phase + 2'd1;
        if (r_phase == 2'd3) begin
          if (!r_nack) begin
            w_retryNext = '0;
            if (r_idx == r_last) begin
              w_busyNext  = 1'b0;
              w_doneNext  = 1'b1;
              w_stateNext = S_IDLE;
            end else begin
              if (r_idx != c_IDX_MAX) w_idxNext = r_idx + 1'b1;
              w_stateNext = S_LOAD;
            end
          end else if (r_retry < c_RT_W'(MAX_RETRY)) begin
            w_retryNext = r_retry + 1'b1;
            w_stateNext = S_LOAD;
          end else begin
            w_busyNext  = 1'b0;
            w_errorNext = 1'b1;
            w_stateNext = S_IDLE;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
